// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// A blocking FSM evicts a dirty victim and then refills the line; the held CPU request then hits.
module data_cache #(
  parameter int LINE_SIZE  = 16,
  parameter int NUM_SETS   = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic [31:0]  addr,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic [31:0]  dout,
  output logic         is_hit,
  output logic         dmem_is_input_valid,
  output logic [31:0]  dmem_addr,
  output logic         dmem_read,
  output logic         dmem_write,
  output logic [127:0] dmem_din,
  input  logic         dmem_is_output_valid,
  input  logic [127:0] dmem_dout,
  input  logic         dmem_ready
);
  localparam int LINE_BITS = LINE_SIZE * 8;
  localparam int TAG_W     = 28 - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_WAIT, S_ALLOC_REQ, S_ALLOC_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [27:0]            miss_blk_q, miss_blk_d;
  logic [NUM_SETS-1:0]    valid_q, valid_d;
  logic [NUM_SETS-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]       tag_q  [NUM_SETS];
  logic [TAG_W-1:0]       tag_d  [NUM_SETS];
  logic [LINE_BITS-1:0]   data_q [NUM_SETS];
  logic [LINE_BITS-1:0]   data_d [NUM_SETS];

  logic [INDEX_BITS-1:0]  index, m_index;
  logic [TAG_W-1:0]       tag, m_tag;
  logic [1:0]             woff;
  logic                   hit, req, wr_req, rd_req;

  assign woff    = addr[3:2];
  assign index   = addr[4 +: INDEX_BITS];
  assign tag     = addr[31:4+INDEX_BITS];
  assign m_index = miss_blk_q[INDEX_BITS-1:0];
  assign m_tag   = miss_blk_q[27:INDEX_BITS];

  // A simultaneous read and write is serviced as a write.
  assign wr_req = mem_write;
  assign rd_req = mem_read & ~mem_write;
  assign req    = is_input_valid & (mem_read | mem_write);
  assign hit    = (state_q == S_IDLE) & is_input_valid & valid_q[index] & (tag_q[index] == tag);
  assign is_hit = hit;

  always_comb begin
    state_d             = state_q;
    miss_blk_d          = miss_blk_q;
    valid_d             = valid_q;
    dirty_d             = dirty_q;
    tag_d               = tag_q;
    data_d              = data_q;
    is_ready            = 1'b0;
    is_output_valid     = 1'b0;
    dout                = '0;
    dmem_is_input_valid = 1'b0;
    dmem_addr           = '0;
    dmem_read           = 1'b0;
    dmem_write          = 1'b0;
    dmem_din            = '0;
    case (state_q)
      S_IDLE: begin
        is_ready = 1'b1;
        if (hit && rd_req) begin
          is_output_valid = 1'b1;
          dout            = data_q[index][{woff, 5'b0} +: 32];
        end else if (hit && wr_req) begin
          data_d[index][{woff, 5'b0} +: 32] = din;
          dirty_d[index]                    = 1'b1;
        end else if (req && !hit) begin
          miss_blk_d = addr[31:4];
          state_d    = (valid_q[index] && dirty_q[index]) ? S_WB_REQ : S_ALLOC_REQ;
        end
      end
      S_WB_REQ: begin
        dmem_is_input_valid = 1'b1;
        dmem_write          = 1'b1;
        dmem_addr           = {4'b0, tag_q[m_index], m_index};
        dmem_din            = data_q[m_index];
        if (dmem_ready) state_d = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (dmem_ready) state_d = S_ALLOC_REQ;
      end
      S_ALLOC_REQ: begin
        dmem_is_input_valid = 1'b1;
        dmem_read           = 1'b1;
        dmem_addr           = {4'b0, miss_blk_q};
        if (dmem_ready) state_d = S_ALLOC_WAIT;
      end
      S_ALLOC_WAIT: begin
        if (dmem_is_output_valid) begin
          data_d[m_index]  = dmem_dout;
          tag_d[m_index]   = m_tag;
          valid_d[m_index] = 1'b1;
          dirty_d[m_index] = 1'b0;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tag and data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      miss_blk_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      miss_blk_q <= miss_blk_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Randomized self-checking bench for data_cache: word-level golden memory plus a
// hit/dirty model predicts every cycle; a fixed-delay block memory sits on the dmem side.
module tb_data_cache;
  logic         clk, reset;
  logic         is_input_valid, mem_read, mem_write;
  logic [31:0]  addr, din;
  logic         is_ready, is_output_valid, is_hit;
  logic [31:0]  dout;
  logic         dmem_is_input_valid, dmem_read, dmem_write;
  logic [31:0]  dmem_addr;
  logic [127:0] dmem_din, dmem_dout;
  logic         dmem_is_output_valid, dmem_ready;

  data_cache dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din),
    .is_ready(is_ready), .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
    .dmem_is_input_valid(dmem_is_input_valid), .dmem_addr(dmem_addr),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_din(dmem_din),
    .dmem_is_output_valid(dmem_is_output_valid), .dmem_dout(dmem_dout), .dmem_ready(dmem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-delay block memory: busy for mem_delay cycles after accepting, read data in the last one.
  logic [127:0] mem [256];
  logic         mem_clr, m_busy, m_rd;
  logic [7:0]   m_addr;
  int           m_cnt, mem_delay, n_wr, n_rd;
  logic [31:0]  last_wr_addr, last_rd_addr;
  logic [127:0] last_wr_din;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      n_wr <= 0; n_rd <= 0; last_wr_addr <= '0; last_rd_addr <= '0; last_wr_din <= '0;
      m_addr <= '0; m_rd <= 1'b0;
    end
    if (reset) begin
      m_busy <= 1'b0; m_cnt <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end else if (dmem_is_input_valid) begin
      m_busy <= 1'b1; m_cnt <= mem_delay;
      m_rd   <= dmem_read && !dmem_write;
      m_addr <= dmem_addr[7:0];
      if (dmem_write) begin
        mem[dmem_addr[7:0]] <= dmem_din;
        n_wr <= n_wr + 1; last_wr_addr <= dmem_addr; last_wr_din <= dmem_din;
      end else begin
        n_rd <= n_rd + 1; last_rd_addr <= dmem_addr;
      end
    end
  end
  assign dmem_ready           = !m_busy;
  assign dmem_is_output_valid = m_busy && (m_cnt == 1) && m_rd;
  assign dmem_dout            = mem[m_addr];

  // Reference: flat word memory as the CPU sees it, plus per-set residency/dirty.
  logic [31:0] gold [1024];
  bit          mv [16], md [16];
  int          mt [16];

  int           n_chk, n_pass;
  logic         chk_en, exp_ready, exp_hit, exp_ov, exp_dwr, pend_v;
  logic [31:0]  exp_dout, exp_daddr;
  logic [127:0] exp_ddin, pend_act, pend_exp;
  int           exp_dmode;
  string        pend_nm;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("is_ready", is_ready, exp_ready);
        chk("is_hit", is_hit, exp_hit);
        chk("is_output_valid", is_output_valid, exp_ov);
        chk("dout", dout, exp_dout);
        if (exp_dmode == 1) begin
          chk("dmem_idle_ctl", {dmem_is_input_valid, dmem_read, dmem_write}, 3'b000);
          chk("dmem_idle_addr", dmem_addr, 0);
          chk("dmem_idle_din", dmem_din, 0);
        end else if (exp_dmode == 2) begin
          chk("dmem_req_ctl", {dmem_is_input_valid, dmem_read, dmem_write}, {1'b1, !exp_dwr, exp_dwr});
          chk("dmem_req_addr", dmem_addr, exp_daddr);
          if (exp_dwr) chk("dmem_victim_din", dmem_din, exp_ddin);
        end
      end
      if (pend_v) chk(pend_nm, pend_act, pend_exp);
    end
  end

  task automatic dchk(input string nm, input logic [127:0] a, input logic [127:0] e);
    pend_nm = nm; pend_act = a; pend_exp = e; pend_v = 1'b1;
    @(negedge clk); #1; pend_v = 1'b0;
    @(posedge clk); #1;
  endtask

  // Presents one request and holds it for the latency the reference predicts.
  task automatic do_req(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d,
                        output int lat, output logic [31:0] rdata);
    int idx, tg, wi, ob, L;
    bit act, hit, dty;
    idx = int'(a[7:4]); tg = int'(a[31:8]); wi = int'(a[11:2]);
    act = rd || wr;
    hit = mv[idx] && (mt[idx] == tg);
    dty = mv[idx] && md[idx];
    L   = (!act || hit) ? 1 : (dty ? 2 * mem_delay + 5 : mem_delay + 3);
    ob  = (mt[idx] * 16 + idx) * 4;
    is_input_valid = 1'b1; addr = a; mem_read = rd; mem_write = wr; din = d;
    lat = -1; rdata = '0;
    for (int n = 1; n <= L; n++) begin
      exp_ready = (n == 1) || (n == L);
      exp_hit   = (n == L) && (act || hit);
      exp_ov    = (n == L) && act && rd && !wr;
      exp_dout  = exp_ov ? gold[wi] : 32'h0;
      exp_dmode = exp_ready ? 1 : ((n == 2) ? 2 : 0);
      exp_dwr   = dty;
      exp_daddr = dty ? 32'(mt[idx] * 16 + idx) : {4'b0, a[31:4]};
      exp_ddin  = {gold[ob+3], gold[ob+2], gold[ob+1], gold[ob]};
      chk_en = 1'b1;
      @(negedge clk);
      if (is_hit && lat < 0) lat = n;
      if (n == L) rdata = dout;
      @(posedge clk); #1;
    end
    chk_en = 1'b0; is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if (act && !hit) begin mv[idx] = 1'b1; mt[idx] = tg; md[idx] = 1'b0; end
    if (act && wr) begin md[idx] = 1'b1; gold[wi] = d; end
  endtask

  task automatic idle_cyc();
    is_input_valid = 1'b0; addr = $urandom; mem_read = 1'($urandom); mem_write = 1'($urandom);
    exp_ready = 1'b1; exp_hit = 1'b0; exp_ov = 1'b0; exp_dout = '0; exp_dmode = 1;
    chk_en = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    chk_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  int          lat, rd0, wr0;
  logic [31:0] rdata;
  logic [5:0]  flags;

  initial begin
    reset = 1'b1; mem_clr = 1'b1; mem_delay = 50;
    is_input_valid = 1'b0; addr = '0; mem_read = 1'b0; mem_write = 1'b0; din = '0;
    chk_en = 1'b0; pend_v = 1'b0; pend_nm = ""; pend_act = '0; pend_exp = '0;
    exp_ready = 1'b0; exp_hit = 1'b0; exp_ov = 1'b0; exp_dwr = 1'b0;
    exp_dout = '0; exp_daddr = '0; exp_ddin = '0; exp_dmode = 0;
    for (int i = 0; i < 1024; i++) gold[i] = '0;
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 0; end
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; mem_clr = 1'b0;
    flags = {is_ready, is_output_valid, is_hit, dmem_is_input_valid, dmem_read, dmem_write};
    dchk("reset_flags", flags, 6'b100000);
    dchk("reset_dout", dout, 0);
    dchk("reset_dmem_addr", dmem_addr, 0);
    dchk("reset_dmem_din", dmem_din, 0);

    // Cold read miss, then a re-read hit.
    do_req(32'h100, 1, 0, 0, lat, rdata);
    dchk("cold_miss_latency", lat, 53);
    dchk("cold_miss_dout", rdata, 0);
    dchk("cold_miss_rd_addr", last_rd_addr, 32'h10);
    rd0 = n_rd;
    do_req(32'h100, 1, 0, 0, lat, rdata);
    dchk("reread_latency", lat, 1);
    do_req(32'h104, 0, 1, 32'hDEADBEEF, lat, rdata);
    dchk("write_hit_latency", lat, 1);
    do_req(32'h104, 1, 0, 0, lat, rdata);
    dchk("read_after_write", rdata, 32'hDEADBEEF);
    dchk("hits_no_dmem", {n_rd - rd0, n_wr}, 0);

    // Dirty conflict miss: write-back first, then refill.
    do_req(32'h904, 1, 0, 0, lat, rdata);
    dchk("dirty_miss_latency", lat, 105);
    dchk("wb_addr", last_wr_addr, 32'h10);
    dchk("wb_word1", last_wr_din[63:32], 32'hDEADBEEF);
    dchk("refill_addr", last_rd_addr, 32'h90);
    wr0 = n_wr;
    do_req(32'h104, 1, 0, 0, lat, rdata);
    dchk("clean_evict_latency", lat, 53);
    dchk("clean_evict_no_wb", n_wr - wr0, 0);
    dchk("refill_written_back", rdata, 32'hDEADBEEF);

    // Reset while the refill is outstanding.
    is_input_valid = 1'b1; addr = 32'h904; mem_read = 1'b1;
    repeat (10) @(posedge clk);
    #1; flags = {5'b0, is_ready};
    reset = 1'b1; is_input_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    rdata = {28'b0, is_ready, dmem_is_input_valid, dmem_read, dmem_write};
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
    dchk("busy_before_reset", flags, 0);
    dchk("reset_mid_flags", rdata, 4'b1000);
    dchk("reset_mid_dmem_addr", dmem_addr, 0);
    do_req(32'h104, 1, 0, 0, lat, rdata);
    dchk("post_reset_miss_latency", lat, 53);

    // Fill all sets, then every set must hit without memory traffic.
    for (int i = 0; i < 16; i++) do_req(32'(i * 16), 1, 0, 0, lat, rdata);
    rd0 = n_rd; wr0 = n_wr;
    for (int i = 0; i < 16; i++) begin
      do_req(32'(i * 16), 1, 0, 0, lat, rdata);
      dchk("fill_rehit", lat, 1);
    end
    dchk("fill_rehit_no_dmem", {n_rd - rd0, n_wr - wr0}, 0);
    do_req(32'h108, 0, 1, 32'h12345678, lat, rdata);
    do_req(32'h10C, 1, 0, 0, lat, rdata);
    dchk("neighbour_word_untouched", rdata, 0);
    do_req(32'h108, 1, 0, 0, lat, rdata);
    dchk("written_word", rdata, 32'h12345678);

    // Random traffic over 4 tags x 16 sets with a short memory delay.
    mem_delay = 4;
    for (int k = 0; k < 400; k++) begin
      int op;
      logic [31:0] a;
      a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
      op = $urandom_range(0, 23);
      if (op < 9)       do_req(a, 1, 0, 0, lat, rdata);
      else if (op < 18) do_req(a, 0, 1, $urandom, lat, rdata);
      else if (op == 18) do_req(a, 1, 1, $urandom, lat, rdata);
      else if (op == 19) do_req(a, 0, 0, $urandom, lat, rdata);
      else idle_cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage and the 128-bit-block, fixed-delay data memory.
- CPU side: word-granular requests with a ready/hit stall handshake.
- Memory side: whole-block reads and writes over the data memory's valid/ready protocol.
- A blocking FSM sequences dirty-victim write-back and line allocation on a miss.

Parameters:
- LINE_SIZE, 16, bytes per line; must equal the data memory block size; 4 words per line.
- NUM_SETS, 16, number of lines; power of 2.
- INDEX_BITS, 4, log2(NUM_SETS).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- is_input_valid  input  1  CPU request valid
- addr  input  32  CPU byte address; addr[1:0] ignored
- mem_read  input  1  CPU read request
- mem_write  input  1  CPU write request
- din  input  32  CPU write word
- is_ready  output  1  cache able to service (state IDLE)
- is_output_valid  output  1  dout valid this cycle
- dout  output  32  read word
- is_hit  output  1  current request hits
- dmem_is_input_valid  output  1  request to data memory
- dmem_addr  output  32  block address (byte address >> 4)
- dmem_read  output  1  block read
- dmem_write  output  1  block write
- dmem_din  output  128  victim line data
- dmem_is_output_valid  input  1  block read data valid
- dmem_dout  input  128  block read data
- dmem_ready  input  1  data memory idle (can accept a request)

Behaviour:
- Address split: word offset addr[3:2], index addr[4+INDEX_BITS-1:4], tag addr[31:4+INDEX_BITS].
- Per-line storage: valid, dirty, tag, 128-bit data. Word w occupies bits [32w+31:32w].
- Reset: all valid/dirty cleared, state IDLE, miss latch cleared.
- Output values after reset: is_ready=1, is_output_valid=0, dout=0, is_hit=0, all dmem_* outputs 0.
- Reset mid-miss (any state) returns to IDLE next cycle and drops the outstanding memory transaction.
- is_hit = state==IDLE & is_input_valid & valid[index] & tag match. Combinational.
- is_ready = (state==IDLE).
- CPU stalls while is_input_valid & !(is_ready & is_hit).
- CPU must hold addr/din/mem_read/mem_write stable until the hit.
- mem_read & mem_write both high is treated as a write.
- Read hit: is_output_valid=1 and dout = selected word in the same cycle. Zero-latency.
- Write hit: word written at the clock edge; dirty set. is_output_valid=0.
- Otherwise dout=0.
- FSM states: IDLE, WB_REQ, WB_WAIT, ALLOC_REQ, ALLOC_WAIT.
- IDLE transitions:
  - On a valid miss, latch the address.
  - Go to WB_REQ if the line is valid & dirty, else ALLOC_REQ.
- WB_REQ:
  - Assert dmem_is_input_valid, dmem_write=1, dmem_addr={old tag, index}, dmem_din=line data.
  - Go to WB_WAIT only on a cycle with dmem_ready=1.
- WB_WAIT:
  - dmem outputs deasserted.
  - When dmem_ready=1 (write committed at that edge), go to ALLOC_REQ.
- ALLOC_REQ:
  - Assert dmem_is_input_valid, dmem_read=1, dmem_addr = latched addr[31:4].
  - Go to ALLOC_WAIT on a cycle with dmem_ready=1.
- ALLOC_WAIT:
  - When dmem_is_output_valid=1, write dmem_dout to the line; valid=1, dirty=0, tag=new tag.
  - Go to IDLE. The held request then hits.
- Latency with memory DELAY=D: clean miss hits in cycle D+3 after first presentation; dirty miss hits in cycle 2D+5.
- Requests with is_input_valid=0, or neither read nor write, cause no state change.

Test Plan:
- Reset, read 0x100 → dmem_read with dmem_addr=0x10. is_output_valid=1, dout=0 at cycle 53 (D=50). Then re-read 0x100 → hit in the same cycle, no dmem request.
- Write 0xDEADBEEF to 0x104 after the fill → is_hit=1 same cycle. Read 0x104 → dout=0xDEADBEEF. Line dirty, no dmem traffic.
- Read 0x904 (index 0, tag 0x9, conflicts with the dirty line) → first dmem_write to dmem_addr=0x10 with dmem_din[63:32]=0xDEADBEEF. Then dmem_read to 0x90. Hit at cycle 105.
- Read 0x104 again → clean eviction, no dmem_write. Refill returns dout=0xDEADBEEF at cycle 53.
- Assert reset during ALLOC_WAIT → next cycle IDLE, all dmem_* outputs 0. Subsequent read of 0x104 misses.
- Fill 0x000,0x010,…,0x0F0 (16 sets) → re-reading all 16 addresses hits with no dmem requests. Writing 0x108 then reading 0x10C returns the old word 3 unchanged.
